// File: rtl/c17_bist_pkg.sv
// Shared constants, types and the LFSR step used by the c17 BIST block.
// The PRPG and MISR both use the same Galois polynomial.
package c17_bist_pkg;

    localparam logic [31:0] POLY = 32'h80200003;

    typedef enum logic [2:0] {
        NODE_G10  = 3'd0,
        NODE_G11  = 3'd1,
        NODE_G16  = 3'd2,
        NODE_G19  = 3'd3,
        NODE_G22  = 3'd4,
        NODE_G23  = 3'd5,
        NODE_NONE = 3'd6
    } node_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? POLY : 32'h0);
    endfunction

endpackage

// File: rtl/c17_bist_core.sv
// One c17 lane: six NANDs, optional stage register after the G10/G16/G19
// level, stuck-at override on any node, and the lane's response register.
module c17_core
    import c17_bist_pkg::*;
#(
    parameter int PIPE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] pat,
    input  logic       cap,
    input  logic       inj_en,
    input  logic [2:0] inj_node,
    input  logic       inj_val,
    output logic [1:0] resp
);

    logic       g1, g2, g3, g6, g7;
    logic       g10, g11, g16, g19, g22, g23;
    logic [5:0] hit;
    logic [2:0] s1_d, s1;
    logic [1:0] resp_d, resp_q;

    assign {g7, g6, g3, g2, g1} = pat;

    // Node codes 6 and 7 shift out of the 6-bit mask, so they select nothing.
    assign hit = inj_en ? 6'(6'b1 << inj_node) : 6'b0;

    always_comb begin
        g10  = hit[0] ? inj_val : ~(g1 & g3);
        g11  = hit[1] ? inj_val : ~(g3 & g6);
        g16  = hit[2] ? inj_val : ~(g2 & g11);
        g19  = hit[3] ? inj_val : ~(g11 & g7);
        s1_d = {g10, g16, g19};
    end

    if (PIPE != 0) begin : g_pipe
        logic [2:0] s1_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) s1_q <= '0;
            else        s1_q <= s1_d;
        end
        assign s1 = s1_q;
    end else begin : g_flat
        assign s1 = s1_d;
    end

    always_comb begin
        g22    = hit[4] ? inj_val : ~(s1[2] & s1[1]);
        g23    = hit[5] ? inj_val : ~(s1[1] & s1[0]);
        resp_d = cap ? {g23, g22} : resp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) resp_q <= '0;
        else        resp_q <= resp_d;
    end

    assign resp = resp_q;

endmodule

// File: rtl/c17_bist.sv
// c17 BIST top: run FSM, PRPG, pattern counter, valid pipeline and MISR
// around LANES copies of the c17 network.
module c17_bist
    import c17_bist_pkg::*;
#(
    parameter int          LANES = 1,
    parameter int          PIPE  = 0,
    parameter int          N_PAT = 256,
    parameter logic [31:0] SEED  = 32'h0000001F
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               inj_en,
    input  logic [2:0]         inj_node,
    input  logic               inj_val,
    output logic               busy,
    output logic               done,
    output logic [31:0]        signature,
    output logic [2*LANES-1:0] resp
);

    localparam int CW = $clog2(N_PAT + 1);
    localparam int RW = 2 * LANES;

    state_e          state_d, state_q;
    logic [31:0]     prpg_d, prpg_q, misr_d, misr_q;
    logic [CW-1:0]   cnt_d, cnt_q;
    logic            drain_d, drain_q;
    logic            inj_en_d, inj_en_q, inj_val_d, inj_val_q;
    logic [2:0]      inj_node_d, inj_node_q;
    logic [PIPE:0]   vld_d, vld_q;
    logic            issue, cap;

    assign issue = (state_q == ST_RUN) && (cnt_q != CW'(N_PAT));

    // vld_q[PIPE] marks a valid resp; cap is the valid bit at the resp input.
    if (PIPE != 0) begin : g_vp
        assign vld_d = {vld_q[0], issue};
        assign cap   = vld_q[0];
    end else begin : g_vn
        assign vld_d = issue;
        assign cap   = issue;
    end

    always_comb begin
        state_d    = state_q;
        prpg_d     = prpg_q;
        misr_d     = misr_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        inj_en_d   = inj_en_q;
        inj_node_d = inj_node_q;
        inj_val_d  = inj_val_q;
        if (vld_q[PIPE]) misr_d = lfsr_step(misr_q) ^ {{(32-RW){1'b0}}, resp};
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    prpg_d     = SEED;
                    misr_d     = '0;
                    cnt_d      = '0;
                    inj_en_d   = inj_en;
                    inj_node_d = inj_node;
                    inj_val_d  = inj_val;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    prpg_d = lfsr_step(prpg_q);
                    cnt_d  = cnt_q + 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                    drain_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (drain_q == 1'(PIPE)) state_d = ST_DONE;
                else                     drain_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            prpg_q     <= SEED;
            misr_q     <= '0;
            cnt_q      <= '0;
            drain_q    <= 1'b0;
            inj_en_q   <= 1'b0;
            inj_node_q <= 3'(NODE_NONE);
            inj_val_q  <= 1'b0;
            vld_q      <= '0;
        end else begin
            state_q    <= state_d;
            prpg_q     <= prpg_d;
            misr_q     <= misr_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            inj_en_q   <= inj_en_d;
            inj_node_q <= inj_node_d;
            inj_val_q  <= inj_val_d;
            vld_q      <= vld_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        c17_core #(.PIPE(PIPE)) u_core (
            .clk      (clk),
            .rst_n    (rst_n),
            .pat      (prpg_q[5*k+4:5*k]),
            .cap      (cap),
            .inj_en   ((k == 0) ? inj_en_q : 1'b0),
            .inj_node ((k == 0) ? inj_node_q : 3'(NODE_NONE)),
            .inj_val  ((k == 0) ? inj_val_q : 1'b0),
            .resp     (resp[2*k+1:2*k])
        );
    end

    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign signature = misr_q;

endmodule

// File: tb/tb_c17_bist.sv
// Directed bench for c17_bist: fixed-vector scenarios across several
// parameter sets plus a model-fed scoreboard on a wide pipelined instance.
module tb_c17_bist;

    localparam logic [31:0] POLY_M = 32'h80200003;
    localparam logic [31:0] SEED_E = 32'hACE12345;
    localparam int          NP_E   = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  start;
    logic        inj_en;
    logic [2:0]  inj_node;
    logic        inj_val;
    logic [4:0]  busy, done;
    logic [31:0] sig [5];
    logic [1:0]  resp_a, resp_b, resp_c;
    logic [3:0]  resp_d;
    logic [5:0]  resp_e;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic [5:0] exp_q [$];

    always #5 clk = ~clk;

    c17_bist #(.LANES(1), .PIPE(0), .N_PAT(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .inj_en(inj_en), .inj_node(inj_node),
        .inj_val(inj_val), .busy(busy[0]), .done(done[0]), .signature(sig[0]), .resp(resp_a));
    c17_bist #(.LANES(1), .PIPE(0), .N_PAT(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .inj_en(inj_en), .inj_node(inj_node),
        .inj_val(inj_val), .busy(busy[1]), .done(done[1]), .signature(sig[1]), .resp(resp_b));
    c17_bist #(.LANES(1), .PIPE(1), .N_PAT(1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .inj_en(inj_en), .inj_node(inj_node),
        .inj_val(inj_val), .busy(busy[2]), .done(done[2]), .signature(sig[2]), .resp(resp_c));
    c17_bist #(.LANES(2), .PIPE(0), .N_PAT(1), .SEED(32'h3FF)) u_d (
        .clk(clk), .rst_n(rst_n), .start(start[3]), .inj_en(inj_en), .inj_node(inj_node),
        .inj_val(inj_val), .busy(busy[3]), .done(done[3]), .signature(sig[3]), .resp(resp_d));
    c17_bist #(.LANES(3), .PIPE(1), .N_PAT(NP_E), .SEED(SEED_E)) u_e (
        .clk(clk), .rst_n(rst_n), .start(start[4]), .inj_en(inj_en), .inj_node(inj_node),
        .inj_val(inj_val), .busy(busy[4]), .done(done[4]), .signature(sig[4]), .resp(resp_e));

    function automatic logic [31:0] step_m(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ POLY_M) : (x >> 1);
    endfunction

    // Returns {G23,G22} for one lane, with an optional stuck node.
    function automatic logic [1:0] c17_m(input logic [4:0] p, input logic ie,
                                         input logic [2:0] n, input logic v);
        logic a10, a11, a16, a19, a22, a23;
        a10 = ~(p[0] & p[2]);  if (ie && n == 3'd0) a10 = v;
        a11 = ~(p[2] & p[3]);  if (ie && n == 3'd1) a11 = v;
        a16 = ~(p[1] & a11);   if (ie && n == 3'd2) a16 = v;
        a19 = ~(a11 & p[4]);   if (ie && n == 3'd3) a19 = v;
        a22 = ~(a10 & a16);    if (ie && n == 3'd4) a22 = v;
        a23 = ~(a16 & a19);    if (ie && n == 3'd5) a23 = v;
        return {a23, a22};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at the negedge just after the start edge.
    task automatic kick(input int k);
        @(negedge clk);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, output int lat);
        lat = 0;
        while (!done[k] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] x, m, sig_e;
        logic [5:0]  r, got;

        rst_n = 1'b1; start = '0; inj_en = 1'b0; inj_node = 3'd7; inj_val = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_sig_a", sig[0], 32'h0);
        chk("rst_sig_e", sig[4], 32'h0);
        chk("rst_resp_e", 32'(resp_e), 32'h0);
        rst_n = 1'b1;

        kick(0);
        chk("a_busy_up", 32'(busy[0]), 32'h1);
        wait_done(0, lat);
        chk("a_latency", lat, 3);
        chk("a_busy_dn", 32'(busy[0]), 32'h0);
        chk("a_resp", 32'(resp_a), 32'h1);
        chk("a_sig", sig[0], 32'h1);

        // G11 stuck-at-1; inj_en dropped after start must not matter.
        inj_en = 1'b1; inj_node = 3'd1; inj_val = 1'b1;
        kick(0);
        inj_en = 1'b0;
        chk("a_restart_done", 32'(done[0]), 32'h0);
        chk("a_restart_sig", sig[0], 32'h0);
        wait_done(0, lat);
        chk("a_inj_latency", lat, 3);
        chk("a_inj_resp", 32'(resp_a), 32'h3);
        chk("a_inj_sig", sig[0], 32'h3);

        for (int n = 4; n <= 5; n++) begin
            for (int v = 0; v <= 1; v++) begin
                inj_en = 1'b1; inj_node = 3'(n); inj_val = 1'(v);
                kick(0);
                wait_done(0, lat);
                r = {4'b0, c17_m(5'h1F, 1'b1, 3'(n), 1'(v))};
                chk($sformatf("a_out_inj_n%0d_v%0d", n, v), 32'(resp_a), 32'(r));
                chk($sformatf("a_out_sig_n%0d_v%0d", n, v), sig[0], 32'(r));
            end
        end
        inj_en = 1'b0; inj_node = 3'd7;

        kick(1);
        wait_done(1, lat);
        chk("b_latency", lat, 4);
        chk("b_resp", 32'(resp_b), 32'h0);
        chk("b_sig", sig[1], 32'h80200003);

        kick(2);
        wait_done(2, lat);
        chk("c_latency", lat, 4);
        chk("c_resp", 32'(resp_c), 32'h1);
        chk("c_sig", sig[2], 32'h1);

        kick(3);
        wait_done(3, lat);
        chk("d_sig", sig[3], 32'h5);
        inj_en = 1'b1; inj_node = 3'd1; inj_val = 1'b1;
        kick(3);
        wait_done(3, lat);
        chk("d_inj_resp", 32'(resp_d), 32'h7);
        chk("d_inj_sig", sig[3], 32'h7);
        inj_node = 3'd6;
        kick(3);
        wait_done(3, lat);
        chk("d_node_none_sig", sig[3], 32'h5);

        // Scoreboard run: G16 stuck-at-0 on lane 0 of a 3-lane pipelined instance.
        inj_en = 1'b1; inj_node = 3'd2; inj_val = 1'b0;
        x = SEED_E; m = 32'h0;
        for (int i = 0; i < NP_E; i++) begin
            r = {c17_m(x[14:10], 1'b0, 3'd7, 1'b0),
                 c17_m(x[9:5],   1'b0, 3'd7, 1'b0),
                 c17_m(x[4:0],   1'b1, 3'd2, 1'b0)};
            exp_q.push_back(r);
            m = step_m(m) ^ {26'b0, r};
            x = step_m(x);
        end
        sig_e = m;
        kick(4);
        inj_en = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NP_E; i++) begin
            got = resp_e;
            chk($sformatf("e_resp_%0d", i), 32'(got), 32'(exp_q.pop_front()));
            start[4] = (i == 5 || i == 15);
            @(negedge clk);
        end
        start[4] = 1'b0;
        wait_done(4, lat);
        chk("e_done_seen", 32'(done[4]), 32'h1);
        chk("e_sig", sig[4], sig_e);

        // Abort mid-run, then rerun the same configuration.
        inj_en = 1'b1; inj_node = 3'd2; inj_val = 1'b0;
        kick(4);
        inj_en = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy[4]), 32'h0);
        chk("abort_done", 32'(done[4]), 32'h0);
        chk("abort_sig", sig[4], 32'h0);
        chk("abort_resp", 32'(resp_e), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        inj_en = 1'b1;
        kick(4);
        inj_en = 1'b0;
        wait_done(4, lat);
        chk("e_rerun_latency", lat, NP_E + 3);
        chk("e_rerun_sig", sig[4], sig_e);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
